// File: rtl/rr_arbiter_2to4_pkg.sv
// rr_arbiter_2to4_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   - state_e       : arbiter FSM encoding (ST_IDLE = 0, ST_GRANT = 1)
//   - NUM_REQ       : number of requesters
//   - DEFAULT_TIMEOUT : default maximum grant length (cycles)
//   - rr_pick()     : rotating priority scan starting at a pointer
// Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
package rr_arbiter_2to4_pkg;

    localparam int unsigned NUM_REQ         = 4;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // First set bit of req scanning ptr, ptr+1, ... (mod 4). Scanning the
    // offsets from farthest to nearest lets the nearest hit win.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/grant_dec_2to4.sv
// grant_dec_2to4
// Purely combinational 2-to-4 decode of the arbiter's registered select and
// enable into a one-hot grant vector.
// Ports:
//   i   in  2 : owner index (decoder select)
//   en  in  1 : grant valid (decoder enable)
//   y   out 4 : one-hot grant, en ? (1 << i) : 4'b0000
module grant_dec_2to4
    import rr_arbiter_2to4_pkg::*;
(
    input  logic [1:0]         i,
    input  logic               en,
    output logic [NUM_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_2to4.sv
// rr_arbiter_2to4
// Round-robin arbiter sharing one resource among four requesters. A grant is
// held until the owner drops its request; one dead IDLE cycle separates
// consecutive grants, and the rotation pointer moves past each owner on
// release so every requester is eventually served.
// Optional feature: define ARB_TIMEOUT_EN to bound each grant to
// TIMEOUT_CYCLES cycles; a forced release pulses tmo for one cycle.
// Ports:
//   clk   in  1 : clock, rising edge
//   rst   in  1 : asynchronous active-high reset
//   req   in  4 : per-requester request, held high while owned
//   i     out 2 : registered owner index (valid only with en)
//   en    out 1 : registered grant valid
//   y     out 4 : one-hot grant decoded from i/en (no path from req)
//   busy  out 1 : high while in GRANT
//   tmo   out 1 : one-cycle forced-release pulse (0 without ARB_TIMEOUT_EN)
module rr_arbiter_2to4
    import rr_arbiter_2to4_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [1:0]         i,
    output logic               en,
    output logic [NUM_REQ-1:0] y,
    output logic               busy,
    output logic               tmo
);

    state_e     state_q, state_d;
    logic [1:0] i_q, i_d;
    logic [1:0] ptr_q, ptr_d;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       tmo_q, tmo_d;
`else
    // Parameter is deliberately ignored in this build.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    i_d     = rr_pick(req, ptr_q);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Voluntary release wins over a timeout in the same cycle.
                if (!req[i_q]) begin
                    state_d = ST_IDLE;
                    ptr_d   = i_q + 2'd1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == TmoLast) begin
                    state_d = ST_IDLE;
                    ptr_d   = i_q + 2'd1;
                    tmo_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Counts completed GRANT cycles; restarts at 0 on every new grant.
    always_comb begin
        cnt_d = 8'd0;
        if (state_q == ST_GRANT && state_d == ST_GRANT) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            i_q     <= 2'd0;
            ptr_q   <= 2'd0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign i    = i_q;
    assign en   = (state_q == ST_GRANT);
    assign busy = (state_q == ST_GRANT);

`ifdef ARB_TIMEOUT_EN
    assign tmo = tmo_q;
`else
    assign tmo = 1'b0;
`endif

    grant_dec_2to4 u_dec (
        .i  (i_q),
        .en (en),
        .y  (y)
    );

endmodule

// File: tb/tb_rr_arbiter_2to4.sv
// Directed bench for rr_arbiter_2to4. Each step drives req, pushes the
// expected post-edge outputs to a scoreboard queue, then pops and compares
// after the clock edge. Build with ARB_TIMEOUT_EN defined to cover the
// forced-release path (TIMEOUT_CYCLES = 4).
module tb_rr_arbiter_2to4;

    typedef struct packed {
        logic [3:0] y;
        logic       tmo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] i;
    logic       en;
    logic [3:0] y;
    logic       busy;
    logic       tmo;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    rr_arbiter_2to4 #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .i    (i),
        .en   (en),
        .y    (y),
        .busy (busy),
        .tmo  (tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) r = 2'(k);
        end
        return r;
    endfunction

    // Pop one expectation and compare all outputs against it.
    task automatic check_pop(input string tag);
        exp_t e;
        e = sb.pop_front();
        n_checks++;
        assert (y === e.y) else begin
            n_fail++;
            $error("FAIL %s y: observed %b expected %b", tag, y, e.y);
        end
        n_checks++;
        assert (en === (|e.y)) else begin
            n_fail++;
            $error("FAIL %s en: observed %b expected %b", tag, en, |e.y);
        end
        n_checks++;
        assert (busy === (|e.y)) else begin
            n_fail++;
            $error("FAIL %s busy: observed %b expected %b", tag, busy, |e.y);
        end
        n_checks++;
        assert (tmo === e.tmo) else begin
            n_fail++;
            $error("FAIL %s tmo: observed %b expected %b", tag, tmo, e.tmo);
        end
        if (|e.y) begin
            n_checks++;
            assert (i === onehot_idx(e.y)) else begin
                n_fail++;
                $error("FAIL %s i: observed %0d expected %0d", tag, i, onehot_idx(e.y));
            end
        end
    endtask

    // Drive req for one edge and check the outputs that edge produces.
    task automatic step(input logic [3:0] r, input logic [3:0] ey, input logic et,
                        input string tag);
        req = r;
        sb.push_back('{y: ey, tmo: et});
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back('{y: 4'b0000, tmo: 1'b0});
        check_pop("reset");
        n_checks++;
        assert (i === 2'd0) else begin
            n_fail++;
            $error("FAIL reset i: observed %0d expected 0", i);
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] all_but;
        logic [3:0] gnt;

        // Single request, release, pointer moves to 3.
        do_reset();
        step(4'b0000, 4'b0000, 1'b0, "idle_no_req");
        step(4'b0100, 4'b0100, 1'b0, "grant2");
        step(4'b0100, 4'b0100, 1'b0, "hold2");
        step(4'b0000, 4'b0000, 1'b0, "release2");
        // ptr = 3: wrap-around to 0 then 1.
        step(4'b0011, 4'b0001, 1'b0, "wrap_grant0");
        step(4'b0011, 4'b0001, 1'b0, "wrap_hold0");
        step(4'b0010, 4'b0000, 1'b0, "wrap_release0");
        step(4'b0010, 4'b0010, 1'b0, "wrap_grant1");
        step(4'b0000, 4'b0000, 1'b0, "wrap_release1");

        // All four requesting: order 0,1,2,3,0 with one dead cycle each.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            gnt     = 4'b0001 << n;
            all_but = 4'b1111 & ~gnt;
            step(4'b1111, gnt, 1'b0, "rr_grant");
            step(4'b1111, gnt, 1'b0, "rr_hold");
            step(all_but, 4'b0000, 1'b0, "rr_dead");
        end
        step(4'b1111, 4'b0001, 1'b0, "rr_wrap0");

        // Request dropped in the cycle its grant registers.
        do_reset();
        step(4'b1000, 4'b1000, 1'b0, "short_grant3");
        step(4'b0000, 4'b0000, 1'b0, "short_release3");
        // Release and a new request together: arbitrated one cycle later.
        step(4'b0001, 4'b0001, 1'b0, "rel_new_grant0");
        step(4'b0100, 4'b0000, 1'b0, "rel_new_dead");
        step(4'b0100, 4'b0100, 1'b0, "rel_new_grant2");
        step(4'b0000, 4'b0000, 1'b0, "rel_new_release2");

        // Asynchronous reset in the middle of a grant to requester 1.
        do_reset();
        step(4'b0010, 4'b0010, 1'b0, "pre_rst_grant1");
        #3;
        rst = 1'b1;
        #1;
        sb.push_back('{y: 4'b0000, tmo: 1'b0});
        check_pop("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(4'b1110, 4'b0010, 1'b0, "post_rst_grant1");
        step(4'b1100, 4'b0000, 1'b0, "post_rst_release1");

        // Single persistent requester.
        do_reset();
`ifdef ARB_TIMEOUT_EN
        for (int n = 0; n < 4; n++) step(4'b0001, 4'b0001, 1'b0, "tmo_hold");
        step(4'b0001, 4'b0000, 1'b1, "tmo_force");
        step(4'b0001, 4'b0001, 1'b0, "tmo_regrant");
        step(4'b0001, 4'b0001, 1'b0, "tmo_regrant_hold");
`else
        for (int n = 0; n < 100; n++) step(4'b0001, 4'b0001, 1'b0, "persist_hold");
        step(4'b0000, 4'b0000, 1'b0, "persist_release");
        step(4'b0001, 4'b0001, 1'b0, "persist_regrant");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
